// File: rtl/sng_pkg.sv
// Shared types and constants for the stochastic-number generator and its
// downstream counters.
package sng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sng_state_e;

    localparam logic [15:0] LFSR_MASK     = 16'hB400;
    localparam logic [15:0] SEED_FALLBACK = 16'h0001;

    localparam logic [1:0] MODE_UNIPOLAR = 2'd0;
    localparam logic [1:0] MODE_BIPOLAR  = 2'd1;
    localparam logic [1:0] MODE_TWO_LINE = 2'd2;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/sn_generator_if.sv
// Request/stream bundle between a stream controller (master) and sn_generator (slave).
interface sn_generator_if #(parameter int WIDTH = 8);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] value_p;
    logic [WIDTH-1:0] value_n;
    logic [15:0]      seed;
    logic [31:0]      length;
    logic             sn_out_p;
    logic             sn_out_n;
    logic             sn_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, value_p, value_n, seed, length,
        input  sn_out_p, sn_out_n, sn_valid, busy, done
    );

    modport slave (
        input  start, stop, value_p, value_n, seed, length,
        output sn_out_p, sn_out_n, sn_valid, busy, done
    );
endinterface

// File: rtl/sng_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load (zero seed maps to 1) and advance.
module sng_lfsr16
    import sng_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        adv_i,
    input  logic [15:0] seed_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i)
            state_d = (seed_i == 16'h0000) ? SEED_FALLBACK : seed_i;
        else if (adv_i)
            state_d = lfsr_step(state_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= SEED_FALLBACK;
        else       state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/sn_generator.sv
// Stochastic bitstream generator: LFSR-vs-magnitude comparators on P/N lines.
// Optional macro SNG_HOLD_EN adds a hold_i stall input.
module sn_generator
    import sng_pkg::*;
#(
    parameter int         WIDTH = 8,
    parameter logic [1:0] MODE  = MODE_UNIPOLAR
) (
    input  logic clk_i,
    input  logic rst_i,
`ifdef SNG_HOLD_EN
    input  logic hold_i,
`endif
    sn_generator_if.slave bus
);

    sng_state_e       state_q;
    logic [31:0]      rem_q;
    logic [WIDTH-1:0] vp_q, vn_q;
    logic             p_q, n_q, valid_q, busy_q, done_q;

    logic [15:0]      lfsr;
    logic [WIDTH-1:0] r_p, r_n;
    logic             lfsr_load, run_step;

    assign lfsr_load = (state_q == ST_IDLE) && bus.start && !bus.stop && (bus.length != 32'd0);
`ifdef SNG_HOLD_EN
    assign run_step  = (state_q == ST_RUN) && !bus.stop && !hold_i;
`else
    assign run_step  = (state_q == ST_RUN) && !bus.stop;
`endif

    sng_lfsr16 u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (lfsr_load),
        .adv_i   (run_step),
        .seed_i  (bus.seed),
        .state_o (lfsr)
    );

    // N line samples the bit-reversed LFSR so it decorrelates from the P line.
    always_comb begin
        r_p = lfsr[WIDTH-1:0];
        r_n = '0;
        for (int i = 0; i < WIDTH; i++) r_n[i] = lfsr[15-i];
    end

    // Outputs describe the state being left at each edge, so they trail state_q by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            vp_q    <= '0;
            vn_q    <= '0;
            p_q     <= 1'b0;
            n_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            p_q     <= 1'b0;
            n_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        vp_q    <= bus.value_p;
                        vn_q    <= bus.value_n;
                        rem_q   <= bus.length;
                        state_q <= (bus.length == 32'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_q <= ST_IDLE;
                    end else begin
                        busy_q <= 1'b1;
                        if (run_step) begin
                            valid_q <= 1'b1;
                            p_q     <= (r_p < vp_q);
                            n_q     <= (MODE == MODE_TWO_LINE) ? (r_n < vn_q) : 1'b0;
                            rem_q   <= rem_q - 32'd1;
                            if (rem_q == 32'd1) state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (!bus.stop) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.sn_out_p = p_q;
    assign bus.sn_out_n = n_q;
    assign bus.sn_valid = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_sn_generator.sv
// Directed bench for sn_generator: a MODE 0 and a MODE 2 instance driven in lockstep.
module tb_sn_generator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0;
    logic [7:0]  vp = '0, vn = '0;
    logic [15:0] seed = '0;
    logic [31:0] len = '0;
`ifdef SNG_HOLD_EN
    logic        hold = 1'b0;
`endif

    always #5 clk = ~clk;

    sn_generator_if #(.WIDTH(8)) if0 ();
    sn_generator_if #(.WIDTH(8)) if2 ();

    assign if0.start = start;  assign if2.start = start;
    assign if0.stop = stop;    assign if2.stop = stop;
    assign if0.value_p = vp;   assign if2.value_p = vp;
    assign if0.value_n = vn;   assign if2.value_n = vn;
    assign if0.seed = seed;    assign if2.seed = seed;
    assign if0.length = len;   assign if2.length = len;

    sn_generator #(.WIDTH(8), .MODE(2'd0)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
`ifdef SNG_HOLD_EN
        .hold_i(hold),
`endif
        .bus   (if0)
    );

    sn_generator #(.WIDTH(8), .MODE(2'd2)) dut2 (
        .clk_i (clk),
        .rst_i (rst),
`ifdef SNG_HOLD_EN
        .hold_i(hold),
`endif
        .bus   (if2)
    );

    int n_chk = 0, n_fail = 0;
    int cyc, nvalid, nbusy, ndone, done_cyc, first_v, last_v, bad_idle;
    int ones_p0, ones_n0, ones_p2, ones_n2, diff;
    logic [15:0] bits_p0, bits_p2, bits_n2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        cyc = 0; nvalid = 0; nbusy = 0; ndone = 0; done_cyc = 0;
        first_v = 0; last_v = 0; bad_idle = 0;
        ones_p0 = 0; ones_n0 = 0; ones_p2 = 0; ones_n2 = 0;
        bits_p0 = '0; bits_p2 = '0; bits_n2 = '0;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cyc++;
            if (if0.sn_valid) begin
                if (nvalid < 16) begin
                    bits_p0[nvalid] = if0.sn_out_p;
                    bits_p2[nvalid] = if2.sn_out_p;
                    bits_n2[nvalid] = if2.sn_out_n;
                end
                if (first_v == 0) first_v = cyc;
                last_v = cyc;
                nvalid++;
                ones_p0 += int'(if0.sn_out_p);
                ones_n0 += int'(if0.sn_out_n);
                ones_p2 += int'(if2.sn_out_p);
                ones_n2 += int'(if2.sn_out_n);
            end else if (if0.sn_out_p || if0.sn_out_n || if2.sn_out_p || if2.sn_out_n || if2.sn_valid) begin
                bad_idle++;
            end
            if (if0.busy) nbusy++;
            if (if0.done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = cyc;
            end
        end
    endtask

    task automatic go(input logic [15:0] s, input logic [7:0] p, input logic [7:0] n, input logic [31:0] l);
        seed = s; vp = p; vn = n; len = l;
        start = 1'b1;
        tick();
        start = 1'b0;
        clr();
    endtask

    function automatic logic [9:0] outs();
        return {if0.sn_valid, if0.sn_out_p, if0.sn_out_n, if0.busy, if0.done,
                if2.sn_valid, if2.sn_out_p, if2.sn_out_n, if2.busy, if2.done};
    endfunction

    initial begin
        clr();
        tick(); tick();
        chk("reset_outs", 32'(outs()), 0);
        rst = 1'b0;
        tick();

        // Seed 1 walks 0001,B400,5A00,2D00,1680,0B40,... ; low bytes vs 0x50 give 0x782F.
        go(16'h0001, 8'h50, 8'h40, 32'd16);
        watch(18);
        chk("pat_p_mode0", 32'(bits_p0), 32'h782F);
        chk("pat_p_mode2", 32'(bits_p2), 32'h782F);
        chk("pat_n_mode2", 32'(bits_n2[3:0]), 32'h3);
        chk("n_zero_mode0", ones_n0, 0);
        chk("pat_nvalid", nvalid, 16);
        chk("pat_first_valid", first_v, 1);
        chk("pat_last_valid", last_v, 16);
        chk("pat_done_cyc", done_cyc, 17);
        chk("pat_ndone", ndone, 1);
        chk("pat_nbusy", nbusy, 17);
        chk("pat_bad_idle", bad_idle, 0);

        go(16'h0000, 8'h50, 8'h40, 32'd16);
        watch(18);
        chk("seed0_pat", 32'(bits_p0), 32'h782F);

        go(16'hACE1, 8'h00, 8'h00, 32'd256);
        watch(258);
        chk("v0_nvalid", nvalid, 256);
        chk("v0_ones", ones_p0, 0);
        chk("v0_done_cyc", done_cyc, 257);
        chk("v0_nbusy", nbusy, 257);

        go(16'h0001, 8'h80, 8'h00, 32'd0);
        watch(3);
        chk("len0_done_cyc", done_cyc, 1);
        chk("len0_nvalid", nvalid, 0);
        chk("len0_nbusy", nbusy, 1);

        go(16'h0005, 8'h80, 8'h80, 32'd100);
        watch(10);
        stop = 1'b1;
        watch(1);
        chk("stop_outs", 32'(outs()), 0);
        stop = 1'b0;
        watch(110);
        chk("stop_nvalid", nvalid, 10);
        chk("stop_ndone", ndone, 0);

        go(16'h0005, 8'h80, 8'h80, 32'd100);
        watch(10);
        rst = 1'b1;
        watch(1);
        chk("rst_outs", 32'(outs()), 0);
        rst = 1'b0;
        watch(110);
        chk("rst_nvalid", nvalid, 10);
        chk("rst_ndone", ndone, 0);

        go(16'h0077, 8'h00, 8'h00, 32'd20);
        watch(5);
        len = 32'd3;
        start = 1'b1;
        watch(1);
        start = 1'b0;
        watch(20);
        chk("restart_ign_nvalid", nvalid, 20);
        chk("restart_ign_done", done_cyc, 21);

        stop = 1'b1; start = 1'b1; len = 32'd5;
        tick();
        stop = 1'b0; start = 1'b0;
        clr();
        watch(10);
        chk("stop_start_idle", nvalid + nbusy + ndone, 0);

        // A full maximal-length period: low byte < 128 in 32767 of the 65535 nonzero states.
        go(16'h0001, 8'd128, 8'h00, 32'd65535);
        watch(65537);
        chk("period_ones", ones_p0, 32767);
        chk("period_nvalid", nvalid, 65535);
        chk("period_done_cyc", done_cyc, 65536);

        go(16'h1234, 8'd255, 8'd255, 32'd1000);
        watch(1002);
        diff = ones_p2 - ones_n2;
        if (diff < 0) diff = -diff;
        chk("m2_p_ge990", 32'(ones_p2 >= 990), 1);
        chk("m2_n_ge990", 32'(ones_n2 >= 990), 1);
        chk("m2_twoline_cnt", 32'(diff <= 50), 1);
        chk("m0_n_zero", ones_n0, 0);

`ifdef SNG_HOLD_EN
        go(16'h0001, 8'h50, 8'h40, 32'd16);
        watch(4);
        hold = 1'b1;
        watch(5);
        hold = 1'b0;
        watch(16);
        chk("hold_pat", 32'(bits_p0), 32'h782F);
        chk("hold_nvalid", nvalid, 16);
        chk("hold_done_cyc", done_cyc, 22);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sn_generator.md
SN_GENERATOR -- requirements
Module: sn_generator

Interface
REQ-001 Parameter WIDTH, default 8: comparator width in bits, legal range 1..16.
REQ-002 Parameter MODE, default 2'd0: 0 = unipolar, 1 = bipolar, 2 = two-line.
REQ-003 CLK  input  1  single clock, all state updates on its rising edge.
REQ-004 RST  input  1  synchronous reset, active-high.
REQ-005 START  input  1  one-cycle request to begin a stream; honoured only in IDLE.
REQ-006 STOP  input  1  abort the current stream.
REQ-007 VALUE_P  input  WIDTH  magnitude for the P line, latched on START.
REQ-008 VALUE_N  input  WIDTH  magnitude for the N line, latched on START; used in MODE 2 only.
REQ-009 SEED  input  16  LFSR seed, latched on START.
REQ-010 LENGTH  input  32  number of stream bits, latched on START.
REQ-011 SN_OUT_P  output  1  stochastic bit, P line.
REQ-012 SN_OUT_N  output  1  stochastic bit, N line.
REQ-013 SN_VALID  output  1  SN_OUT_P/N are valid this cycle; the downstream counter enable.
REQ-014 BUSY  output  1  high in RUN and DONE states.
REQ-015 DONE  output  1  one-cycle pulse at the end of a completed stream.

Function
REQ-016 FSM states: IDLE, RUN, DONE; all outputs are registered.
REQ-017 IDLE + START + LENGTH>0: latch inputs, load remaining = LENGTH, go RUN.
REQ-018 IDLE + START + LENGTH==0: go DONE directly; SN_VALID is never asserted.
REQ-019 LFSR is 16-bit Galois, shift right, feedback mask 16'hB400 applied when lsb=1; SEED==0 loads 16'h0001.
REQ-020 RUN, every cycle: R_P = lfsr[WIDTH-1:0]; R_N = bit-reverse(lfsr)[WIDTH-1:0].
REQ-021 RUN, every cycle: SN_OUT_P <= (R_P < VALUE_P) and SN_VALID <= 1; the LFSR advances one step and remaining decrements.
REQ-022 SN_OUT_N <= (R_N < VALUE_N) in MODE 2; SN_OUT_N <= 0 in MODES 0 and 1.
REQ-023 MODE 1 uses offset-binary VALUE_P, so stream probability = (value+1)/2 as seen by a bipolar counter; the comparator is identical to MODE 0.
REQ-024 RUN with remaining==1 goes to DONE; the stream is exactly LENGTH consecutive SN_VALID cycles.
REQ-025 Timing: START accepted at cycle t; SN_VALID high t+1..t+LENGTH; DONE pulses at t+LENGTH+1; IDLE from t+LENGTH+2.
REQ-026 DONE state lasts one cycle and then returns to IDLE.
REQ-027 START is ignored outside IDLE.
REQ-028 STOP in RUN or DONE: return to IDLE next cycle, no DONE pulse, SN_VALID low from the next cycle.
REQ-029 STOP and START together in IDLE: STOP wins and no stream starts.
REQ-030 Outside RUN: SN_VALID, SN_OUT_P and SN_OUT_N are 0.
REQ-031 LENGTH up to 2^32-1 is legal; the LFSR wraps freely with period 65535.

Reset
REQ-032 RST has priority over all inputs, including mid-stream.
REQ-033 On RST: state = IDLE, lfsr = 16'h0001, remaining = 0, and all outputs = 0.

Configuration
REQ-034 Macro SNG_HOLD_EN defined: adds input port HOLD (1 bit).
REQ-035 With SNG_HOLD_EN, HOLD high in RUN freezes the LFSR and remaining, and forces SN_VALID to 0 next cycle; the stream resumes unchanged when HOLD falls; STOP still overrides HOLD.
REQ-036 SNG_HOLD_EN undefined: no HOLD port and no stall logic.

Structure
REQ-037 Package sng_pkg holds: the state enum; the LFSR mask 16'hB400; the seed-fallback constant 16'h0001; and the MODE encodings shared with the downstream counter.
REQ-038 Sub-module sng_lfsr16 provides the LFSR with synchronous load/advance inputs and a 16-bit state output.

Verification
REQ-039 WIDTH=8, MODE 0, VALUE_P=0, LENGTH=256 -> 256 valid cycles, zero ones, DONE at t+257.
REQ-040 WIDTH=8, VALUE_P=128, SEED=1, LENGTH=65535 -> exactly 32767 ones.
REQ-041 LENGTH=0 -> DONE at t+1, SN_VALID never high, BUSY high for exactly one cycle.
REQ-042 STOP at the 10th valid cycle of LENGTH=100 -> exactly 10 valid cycles, no DONE, IDLE next cycle; the same test with RST instead of STOP gives all outputs 0 the next cycle.
REQ-043 MODE 2, VALUE_P=VALUE_N=255, LENGTH=1000 -> P and N ones counts each at least 990; a downstream two-line counter ends near 0 (within ±50).
REQ-044 SNG_HOLD_EN, HOLD high for 5 cycles mid-stream with SEED=1 -> the bit sequence is identical to an unheld run and DONE arrives 5 cycles later.
